// File: rtl/gpu_sched_pkg.sv
// Shared sizing and state encoding for the scheduler -> core message bus.
package gpu_sched_pkg;

   localparam int BUS_W      = 16;
   localparam int CORE_NUM   = 16;
   localparam int R0_DEPTH   = 8;
   localparam int INSTR_SIZE = 16;
   localparam int R0_AW      = $clog2(R0_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      R0LD = 2'd1,
      HOLD = 2'd2,
      EXEC = 2'd3
   } rx_state_t;

endpackage

// File: rtl/lsb_index.sv
// Combinational lowest-set-bit finder: index of the lowest 1 in vec, valid when vec is nonzero.
module lsb_index #(
   parameter int W  = 8,
   parameter int AW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [AW-1:0] idx,
   output logic          valid
);

   // Scanning from the top down lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) idx = AW'(i);
      end
   end

   assign valid = |vec;

endmodule

// File: rtl/core_msg_rx.sv
// Per-core receiver for the scheduler message bus: captures core select, r0 words and
// one instruction, and reports core_ready / core_reading back to the scheduler.
import gpu_sched_pkg::*;

module core_msg_rx #(
   parameter int CORE_ID = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BUS_W-1:0]      mess_to_core,
   input  logic                  core_mask_loading,
   input  logic                  r0_mask_loading,
   input  logic                  r0_loading,
   input  logic                  instr_loading,
   input  logic                  instr_ack,
   input  logic                  exec_done,
   output logic                  core_ready,
   output logic                  core_reading,
   output logic                  selected,
   output logic                  r0_we,
   output logic [R0_AW-1:0]      r0_waddr,
   output logic [BUS_W-1:0]      r0_wdata,
   output logic                  instr_valid,
   output logic [INSTR_SIZE-1:0] instr,
   output logic                  proto_err
);

   rx_state_t             state_q, state_d;
   logic                  selected_q, selected_d;
   logic [R0_DEPTH-1:0]   r0_pend_q, r0_pend_d;
   logic                  r0_we_q, r0_we_d;
   logic [R0_AW-1:0]      r0_waddr_q, r0_waddr_d;
   logic [BUS_W-1:0]      r0_wdata_q, r0_wdata_d;
   logic                  instr_valid_q, instr_valid_d;
   logic [INSTR_SIZE-1:0] instr_q, instr_d;
   logic                  busy_q, busy_d;
   logic                  core_ready_q, core_ready_d;
   logic                  core_reading_q, core_reading_d;
   logic                  proto_err_q, proto_err_d;

   logic [R0_AW-1:0]      lsb_idx;
   logic                  lsb_valid;
   logic                  win_r0m, win_r0, win_ins, lost;

   lsb_index #(.W(R0_DEPTH), .AW(R0_AW)) u_lsb (
      .vec   (r0_pend_q),
      .idx   (lsb_idx),
      .valid (lsb_valid)
   );

   // Only one strobe is serviced per cycle; any lower-priority strobe alongside it is an error.
   assign win_r0m = r0_mask_loading & ~core_mask_loading;
   assign win_r0  = r0_loading & ~core_mask_loading & ~r0_mask_loading;
   assign win_ins = instr_loading & ~core_mask_loading & ~r0_mask_loading & ~r0_loading;
   assign lost    = (r0_mask_loading & core_mask_loading)
                  | (r0_loading & (core_mask_loading | r0_mask_loading))
                  | (instr_loading & (core_mask_loading | r0_mask_loading | r0_loading));

   always_comb begin
      selected_d     = selected_q;
      r0_pend_d      = r0_pend_q;
      r0_we_d        = 1'b0;
      r0_waddr_d     = r0_waddr_q;
      r0_wdata_d     = r0_wdata_q;
      instr_valid_d  = instr_valid_q;
      instr_d        = instr_q;
      busy_d         = busy_q;
      core_reading_d = core_reading_q;
      proto_err_d    = proto_err_q | (selected_q & lost);

      if (core_mask_loading) begin
         selected_d = mess_to_core[CORE_ID];
         if (lsb_valid) begin
            r0_pend_d   = '0;
            proto_err_d = 1'b1;
         end
      end else if (selected_q) begin
         if (win_r0m) begin
            r0_pend_d = mess_to_core[R0_DEPTH-1:0];
         end else if (win_r0) begin
            if (lsb_valid) begin
               r0_we_d    = 1'b1;
               r0_waddr_d = lsb_idx;
               r0_wdata_d = mess_to_core;
               r0_pend_d  = r0_pend_q & ~(R0_DEPTH'(1) << lsb_idx);
            end else begin
               proto_err_d = 1'b1;
            end
         end else if (win_ins) begin
            if (state_q == IDLE || state_q == EXEC) begin
               instr_d        = mess_to_core[INSTR_SIZE-1:0];
               instr_valid_d  = 1'b1;
               core_reading_d = 1'b0;
            end else begin
               proto_err_d = 1'b1;
            end
         end
      end

      // A done and an ack in the same cycle leave the core busy with the new instruction.
      if (exec_done) busy_d = 1'b0;
      if (instr_ack && instr_valid_q) begin
         instr_valid_d  = 1'b0;
         core_reading_d = 1'b1;
         busy_d         = 1'b1;
      end

      core_ready_d = ~instr_valid_d & ~busy_d & (r0_pend_d == '0);

      if (r0_pend_d != '0)  state_d = R0LD;
      else if (instr_valid_d) state_d = HOLD;
      else if (busy_d)        state_d = EXEC;
      else                    state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         selected_q     <= 1'b0;
         r0_pend_q      <= '0;
         r0_we_q        <= 1'b0;
         r0_waddr_q     <= '0;
         r0_wdata_q     <= '0;
         instr_valid_q  <= 1'b0;
         instr_q        <= '0;
         busy_q         <= 1'b0;
         core_ready_q   <= 1'b1;
         core_reading_q <= 1'b1;
         proto_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         selected_q     <= selected_d;
         r0_pend_q      <= r0_pend_d;
         r0_we_q        <= r0_we_d;
         r0_waddr_q     <= r0_waddr_d;
         r0_wdata_q     <= r0_wdata_d;
         instr_valid_q  <= instr_valid_d;
         instr_q        <= instr_d;
         busy_q         <= busy_d;
         core_ready_q   <= core_ready_d;
         core_reading_q <= core_reading_d;
         proto_err_q    <= proto_err_d;
      end
   end

   assign core_ready   = core_ready_q;
   assign core_reading = core_reading_q;
   assign selected     = selected_q;
   assign r0_we        = r0_we_q;
   assign r0_waddr     = r0_waddr_q;
   assign r0_wdata     = r0_wdata_q;
   assign instr_valid  = instr_valid_q;
   assign instr        = instr_q;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_core_msg_rx.sv
// Directed bench for core_msg_rx (CORE_ID=3) with hand-computed expectations.
import gpu_sched_pkg::*;

module tb_core_msg_rx;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [BUS_W-1:0]      mess_to_core;
   logic                  core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
   logic                  instr_ack, exec_done;
   logic                  core_ready, core_reading, selected, r0_we;
   logic [R0_AW-1:0]      r0_waddr;
   logic [BUS_W-1:0]      r0_wdata;
   logic                  instr_valid;
   logic [INSTR_SIZE-1:0] instr;
   logic                  proto_err;

   int vectors = 0;
   int miscompares = 0;

   core_msg_rx #(.CORE_ID(3)) dut (
      .clk               (clk),
      .reset             (reset),
      .mess_to_core      (mess_to_core),
      .core_mask_loading (core_mask_loading),
      .r0_mask_loading   (r0_mask_loading),
      .r0_loading        (r0_loading),
      .instr_loading     (instr_loading),
      .instr_ack         (instr_ack),
      .exec_done         (exec_done),
      .core_ready        (core_ready),
      .core_reading      (core_reading),
      .selected          (selected),
      .r0_we             (r0_we),
      .r0_waddr          (r0_waddr),
      .r0_wdata          (r0_wdata),
      .instr_valid       (instr_valid),
      .instr             (instr),
      .proto_err         (proto_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Strobes are driven just after an edge, held for exactly one cycle, then released.
   task automatic applyStimulus(input logic cm, input logic r0m, input logic r0,
                                input logic ins, input logic ack, input logic done,
                                input logic rst, input logic [BUS_W-1:0] word);
      core_mask_loading = cm;
      r0_mask_loading   = r0m;
      r0_loading        = r0;
      instr_loading     = ins;
      instr_ack         = ack;
      exec_done         = done;
      reset             = rst;
      mess_to_core      = word;
      @(posedge clk);
      #1;
      core_mask_loading = 1'b0;
      r0_mask_loading   = 1'b0;
      r0_loading        = 1'b0;
      instr_loading     = 1'b0;
      instr_ack         = 1'b0;
      exec_done         = 1'b0;
      reset             = 1'b0;
      mess_to_core      = '0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".core_ready"},   32'(core_ready),   32'h1);
      checkOutput({tag, ".core_reading"}, 32'(core_reading), 32'h1);
      checkOutput({tag, ".proto_err"},    32'(proto_err),    32'h0);
      checkOutput({tag, ".selected"},     32'(selected),     32'h0);
      checkOutput({tag, ".r0_we"},        32'(r0_we),        32'h0);
      checkOutput({tag, ".r0_waddr"},     32'(r0_waddr),     32'h0);
      checkOutput({tag, ".r0_wdata"},     32'(r0_wdata),     32'h0);
      checkOutput({tag, ".instr_valid"},  32'(instr_valid),  32'h0);
      checkOutput({tag, ".instr"},        32'(instr),        32'h0);
   endtask

   initial begin
      reset = 1'b1;
      mess_to_core = '0;
      core_mask_loading = 1'b0;
      r0_mask_loading = 1'b0;
      r0_loading = 1'b0;
      instr_loading = 1'b0;
      instr_ack = 1'b0;
      exec_done = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 1, '0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, '0);
      checkResetState("reset");

      // Selected core receives a two-word r0 load at indices 0 and 2.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0008);
      checkOutput("t1.selected", 32'(selected), 32'h1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h0005);
      checkOutput("t1.ready_during_load", 32'(core_ready), 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hAAAA);
      checkOutput("t1.we0", 32'(r0_we), 32'h1);
      checkOutput("t1.addr0", 32'(r0_waddr), 32'h0);
      checkOutput("t1.data0", 32'(r0_wdata), 32'hAAAA);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hBBBB);
      checkOutput("t1.we1", 32'(r0_we), 32'h1);
      checkOutput("t1.addr1", 32'(r0_waddr), 32'h2);
      checkOutput("t1.data1", 32'(r0_wdata), 32'hBBBB);
      checkOutput("t1.ready_after", 32'(core_ready), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
      checkOutput("t1.we_pulse_end", 32'(r0_we), 32'h0);
      checkOutput("t1.err", 32'(proto_err), 32'h0);

      // Deselected core ignores everything except the core mask.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0004);
      checkOutput("t2.selected", 32'(selected), 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h00FF);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'h1111);
      checkOutput("t2.we", 32'(r0_we), 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h2222);
      checkOutput("t2.instr_valid", 32'(instr_valid), 32'h0);
      checkOutput("t2.err", 32'(proto_err), 32'h0);
      checkOutput("t2.ready", 32'(core_ready), 32'h1);

      // Instruction capture, double load, ack and completion.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0008);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h1234);
      checkOutput("t3.instr_valid", 32'(instr_valid), 32'h1);
      checkOutput("t3.instr", 32'(instr), 32'h1234);
      checkOutput("t3.reading", 32'(core_reading), 32'h0);
      checkOutput("t3.ready", 32'(core_ready), 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'h5678);
      checkOutput("t4.instr_kept", 32'(instr), 32'h1234);
      checkOutput("t4.err", 32'(proto_err), 32'h1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, '0);
      checkOutput("t3.ack_reading", 32'(core_reading), 32'h1);
      checkOutput("t3.ack_valid", 32'(instr_valid), 32'h0);
      checkOutput("t3.busy_not_ready", 32'(core_ready), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
      checkOutput("t3.still_busy", 32'(core_ready), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, '0);
      checkOutput("t3.done_ready", 32'(core_ready), 32'h1);

      // Aborted r0 load via a fresh core mask.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, '0);
      checkResetState("rst2");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0008);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h00FF);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hC000);
      checkOutput("t5.addr0", 32'(r0_waddr), 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hC001);
      checkOutput("t5.addr1", 32'(r0_waddr), 32'h1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hC002);
      checkOutput("t5.addr2", 32'(r0_waddr), 32'h2);
      checkOutput("t5.data2", 32'(r0_wdata), 32'hC002);
      checkOutput("t5.err_before", 32'(proto_err), 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0008);
      checkOutput("t5.err_abort", 32'(proto_err), 32'h1);
      checkOutput("t5.ready", 32'(core_ready), 32'h1);
      checkOutput("t5.we_abort", 32'(r0_we), 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hC003);
      checkOutput("t5.no_more_we", 32'(r0_we), 32'h0);

      // Simultaneous r0 and instr strobes, zero mask, then reset mid-load.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, '0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0008);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h0000);
      checkOutput("t6.zero_mask_ready", 32'(core_ready), 32'h1);
      checkOutput("t6.zero_mask_err", 32'(proto_err), 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h0003);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 16'hD00D);
      checkOutput("t6.we", 32'(r0_we), 32'h1);
      checkOutput("t6.addr", 32'(r0_waddr), 32'h0);
      checkOutput("t6.data", 32'(r0_wdata), 32'hD00D);
      checkOutput("t6.instr_dropped", 32'(instr_valid), 32'h0);
      checkOutput("t6.err", 32'(proto_err), 32'h1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 16'h000F);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 16'hE000);
      checkOutput("t6.r0ld_addr", 32'(r0_waddr), 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 1, 16'hE001);
      checkResetState("t6.midload_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
